// File: rtl/sdmac_reg_decode_ctrl.sv
// rtl/sdmac_reg_decode_ctrl.sv - SDMAC register decode, CNTR/DMAENA and flash access sequencer
// Optional flash registers, FSM and flash port enabled by `define RESDMAC_FLASH_EN.
module sdmac_reg_decode_ctrl #(
  parameter int FA_W = 24
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [7:0]      i_addr,
  input  logic            i_dmac_n,
  input  logic            i_as_n,
  input  logic            i_rw,
  input  logic [31:0]     i_mid,
  input  logic [31:0]     i_fl_rdata,
  input  logic            i_fl_wait,
  output logic            o_wtc_rd_n,
  output logic            o_istr_rd_n,
  output logic            o_dsp_rd_n,
  output logic            o_sspbdat_rd_n,
  output logic            o_version_rd_n,
  output logic            o_contr_wr,
  output logic            o_sspbdat_wr,
  output logic            o_acr_wr,
  output logic            o_st_dma,
  output logic            o_sp_dma,
  output logic            o_clr_int,
  output logic            o_flush_n,
  output logic            o_h_0c,
  output logic            o_h_28,
  output logic            o_wdregreq,
  output logic [8:0]      o_cntr_o,
  output logic            o_intena,
  output logic            o_preset,
  output logic            o_dmadir,
  output logic            o_dmaena,
  output logic [FA_W-1:0] o_flash_addr,
  output logic [31:0]     o_loc_od,
  output logic            o_flash_term,
  output logic [FA_W-1:0] o_fl_addr,
  output logic [31:0]     o_fl_wdata,
  output logic            o_fl_rd,
  output logic            o_fl_wr
);

  logic       w_sel;
  logic [5:0] w_a;
  logic       w_rd;
  logic       w_wr;
  logic [7:0] r_cntr;
  logic       r_dmaena;

  // Decode works on longword index A[7:2]; A[1:0] never participate.
  assign w_sel = ~i_dmac_n & ~i_as_n;
  assign w_a   = i_addr[7:2];
  assign w_rd  = w_sel & i_rw;
  assign w_wr  = w_sel & ~i_rw;

  assign o_wtc_rd_n     = ~(w_rd & (w_a == 6'h01));
  assign o_contr_wr     = w_wr & (w_a == 6'h02);
  assign o_acr_wr       = w_wr & (w_a == 6'h03);
  assign o_h_0c         = w_sel & (w_a == 6'h03);
  assign o_st_dma       = w_sel & (w_a == 6'h04);
  assign o_flush_n      = ~(w_sel & (w_a == 6'h05));
  assign o_clr_int      = w_sel & (w_a == 6'h06);
  assign o_istr_rd_n    = ~(w_rd & (w_a == 6'h07));
  assign o_h_28         = w_sel & (w_a == 6'h0A);
  assign o_dsp_rd_n     = ~(w_rd & (w_a == 6'h0A));
  assign o_sp_dma       = w_sel & (w_a == 6'h0F);
  assign o_wdregreq     = w_sel & (w_a[5:2] == 4'h4);
  assign o_sspbdat_rd_n = ~(w_rd & (w_a == 6'h16));
  assign o_sspbdat_wr   = w_wr & (w_a == 6'h16);
  assign o_version_rd_n = ~(w_rd & (w_a == 6'h18));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cntr   <= 8'h00;
      r_dmaena <= 1'b0;
    end else begin
      if (o_contr_wr)
        r_cntr <= i_mid[7:0];
      if (o_st_dma)
        r_dmaena <= 1'b1;
      else if (o_sp_dma)
        r_dmaena <= 1'b0;
    end
  end

  assign o_cntr_o = {r_dmaena, r_cntr};
  assign o_dmadir = r_cntr[1];
  assign o_intena = r_cntr[2];
  assign o_preset = r_cntr[4];
  assign o_dmaena = r_dmaena;

`ifdef RESDMAC_FLASH_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t          r_state;
  logic [FA_W-1:0] r_flash_addr;
  logic [FA_W-1:0] r_fl_addr;
  logic [31:0]     r_fl_wdata;
  logic [31:0]     r_fl_data;
  logic            r_fl_rd;
  logic            r_fl_wr;
  logic            r_flash_term;
  logic            w_fa_wr;
  logic            w_fd_acc;
  logic            w_op_done;
  logic [1:0]      w_unused_addr;

  assign w_fa_wr       = w_wr & (w_a == 6'h19);
  assign w_fd_acc      = w_sel & (w_a == 6'h1A);
  assign w_op_done     = (r_state == S_REQ) & ~i_fl_wait;
  assign w_unused_addr = i_addr[1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_flash_addr <= '0;
      r_fl_addr    <= '0;
      r_fl_wdata   <= 32'h0;
      r_fl_data    <= 32'h0;
      r_fl_rd      <= 1'b0;
      r_fl_wr      <= 1'b0;
      r_flash_term <= 1'b0;
    end else begin
      // A CPU load of the address register takes priority over the post-op increment.
      if (w_fa_wr)
        r_flash_addr <= i_mid[FA_W-1:0];
      else if (w_op_done)
        r_flash_addr <= r_flash_addr + FA_W'(4);

      case (r_state)
        S_IDLE: begin
          if (w_fd_acc) begin
            r_state   <= S_REQ;
            r_fl_addr <= r_flash_addr;
            if (i_rw) begin
              r_fl_rd <= 1'b1;
            end else begin
              r_fl_wr    <= 1'b1;
              r_fl_wdata <= i_mid;
            end
          end
        end
        S_REQ: begin
          if (!i_fl_wait) begin
            r_state      <= S_DONE;
            r_fl_rd      <= 1'b0;
            r_fl_wr      <= 1'b0;
            r_flash_term <= 1'b1;
            if (r_fl_rd)
              r_fl_data <= i_fl_rdata;
          end
        end
        S_DONE: begin
          if (!w_sel) begin
            r_state      <= S_IDLE;
            r_flash_term <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_fl_rd      <= 1'b0;
          r_fl_wr      <= 1'b0;
          r_flash_term <= 1'b0;
        end
      endcase
    end
  end

  assign o_flash_addr = r_flash_addr;
  assign o_fl_addr    = r_fl_addr;
  assign o_fl_wdata   = r_fl_wdata;
  assign o_fl_rd      = r_fl_rd;
  assign o_fl_wr      = r_fl_wr;
  assign o_flash_term = r_flash_term;

  always_comb begin
    o_loc_od = 32'h0;
    if (w_rd && (w_a == 6'h02))
      o_loc_od = {23'b0, o_cntr_o};
    else if (w_rd && (w_a == 6'h19))
      o_loc_od = 32'(r_flash_addr);
    else if (w_rd && (w_a == 6'h1A))
      o_loc_od = r_fl_data;
  end
`else
  logic w_unused_in;

  assign w_unused_in  = ^{i_fl_rdata, i_fl_wait, i_mid[31:8], i_addr[1:0]};
  assign o_flash_addr = '0;
  assign o_fl_addr    = '0;
  assign o_fl_wdata   = 32'h0;
  assign o_fl_rd      = 1'b0;
  assign o_fl_wr      = 1'b0;
  assign o_flash_term = 1'b0;

  always_comb begin
    o_loc_od = 32'h0;
    if (w_rd && (w_a == 6'h02))
      o_loc_od = {23'b0, o_cntr_o};
  end
`endif

endmodule

// File: tb/tb_sdmac_reg_decode_ctrl.sv
// tb/tb_sdmac_reg_decode_ctrl.sv - directed scoreboard bench for sdmac_reg_decode_ctrl
module tb_sdmac_reg_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic        dmac_n, as_n, rw;
  logic [31:0] mid, fl_rdata;
  logic        fl_wait;
  logic        wtc_rd_n, istr_rd_n, dsp_rd_n, sspbdat_rd_n, version_rd_n;
  logic        contr_wr, sspbdat_wr, acr_wr, st_dma, sp_dma, clr_int, flush_n;
  logic        h_0c, h_28, wdregreq;
  logic [8:0]  cntr_o;
  logic        intena, preset, dmadir, dmaena;
  logic [23:0] flash_addr, fl_addr;
  logic [31:0] loc_od, fl_wdata;
  logic        flash_term, fl_rd, fl_wr;
  logic [14:0] vec;

  string       q_tag[$];
  logic [31:0] q_exp[$];
  int          n_pass = 0;
  int          n_total = 0;

  localparam logic [14:0] IDLE_V = 15'b111111_000000000;

  sdmac_reg_decode_ctrl #(.FA_W(24)) dut (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_dmac_n(dmac_n), .i_as_n(as_n),
    .i_rw(rw), .i_mid(mid), .i_fl_rdata(fl_rdata), .i_fl_wait(fl_wait),
    .o_wtc_rd_n(wtc_rd_n), .o_istr_rd_n(istr_rd_n), .o_dsp_rd_n(dsp_rd_n),
    .o_sspbdat_rd_n(sspbdat_rd_n), .o_version_rd_n(version_rd_n),
    .o_contr_wr(contr_wr), .o_sspbdat_wr(sspbdat_wr), .o_acr_wr(acr_wr),
    .o_st_dma(st_dma), .o_sp_dma(sp_dma), .o_clr_int(clr_int), .o_flush_n(flush_n),
    .o_h_0c(h_0c), .o_h_28(h_28), .o_wdregreq(wdregreq), .o_cntr_o(cntr_o),
    .o_intena(intena), .o_preset(preset), .o_dmadir(dmadir), .o_dmaena(dmaena),
    .o_flash_addr(flash_addr), .o_loc_od(loc_od), .o_flash_term(flash_term),
    .o_fl_addr(fl_addr), .o_fl_wdata(fl_wdata), .o_fl_rd(fl_rd), .o_fl_wr(fl_wr)
  );

  always #5 clk = ~clk;

  assign vec = {wtc_rd_n, istr_rd_n, dsp_rd_n, sspbdat_rd_n, version_rd_n, flush_n,
                contr_wr, sspbdat_wr, acr_wr, st_dma, sp_dma, clr_int, h_0c, h_28, wdregreq};

  task automatic push(input string tag, input logic [31:0] exp);
    q_tag.push_back(tag);
    q_exp.push_back(exp);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_total++;
    if (q_exp.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
      return;
    end
    t = q_tag.pop_front();
    e = q_exp.pop_front();
    assert (obs === e) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", t, obs, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [7:0] a, input logic r, input logic [31:0] d);
    addr = a; rw = r; mid = d; dmac_n = 1'b0; as_n = 1'b0;
    #1;
  endtask

  task automatic idle();
    dmac_n = 1'b1; as_n = 1'b1; addr = 8'h00; rw = 1'b1;
  endtask

  // Combinational decode probe, kept clear of any rising edge.
  task automatic dec(input string tag, input logic [7:0] a, input logic r,
                     input logic csn, input logic asn, input logic [14:0] exp);
    @(negedge clk);
    addr = a; rw = r; dmac_n = csn; as_n = asn; mid = 32'h0;
    push(tag, 32'(exp));
    #1;
    chk(32'(vec));
    idle();
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "FAIL watchdog");
  end

  initial begin
    rst = 1'b1; fl_wait = 1'b0; fl_rdata = 32'h0; mid = 32'h0;
    idle();
    tick(); tick();
    push("rst_cntr", 32'h0); push("rst_dmaena", 32'h0); push("rst_faddr", 32'h0);
    push("rst_term", 32'h0); push("rst_flrd", 32'h0); push("rst_flwr", 32'h0);
    chk(32'(cntr_o)); chk(32'(dmaena)); chk(32'(flash_addr));
    chk(32'(flash_term)); chk(32'(fl_rd)); chk(32'(fl_wr));
    rst = 1'b0;

    bus(8'h08, 1'b0, 32'h16);
    push("contr_wr", 32'h1); chk(32'(contr_wr));
    tick(); idle();
    push("cntr_wr_val", 32'h016); push("dmadir", 32'h1); push("intena", 32'h1); push("preset", 32'h1);
    chk(32'(cntr_o)); chk(32'(dmadir)); chk(32'(intena)); chk(32'(preset));
    bus(8'h08, 1'b1, 32'h0);
    push("cntr_rd", 32'h16); chk(loc_od);
    idle();

    bus(8'h10, 1'b1, 32'h0); tick(); idle();
    push("dmaena_set", 32'h1); push("cntr_dmaena", 32'h116);
    chk(32'(dmaena)); chk(32'(cntr_o));
    bus(8'h3C, 1'b0, 32'h0); tick(); idle();
    push("dmaena_clr", 32'h0); push("cntr_after_sp", 32'h016);
    chk(32'(dmaena)); chk(32'(cntr_o));

    dec("dec_04r",  8'h04, 1'b1, 1'b0, 1'b0, 15'b011111_000000000);
    dec("dec_04w",  8'h04, 1'b0, 1'b0, 1'b0, IDLE_V);
    dec("dec_08w",  8'h08, 1'b0, 1'b0, 1'b0, 15'b111111_100000000);
    dec("dec_0Dw",  8'h0D, 1'b0, 1'b0, 1'b0, 15'b111111_001000100);
    dec("dec_0Cr",  8'h0C, 1'b1, 1'b0, 1'b0, 15'b111111_000000100);
    dec("dec_10r",  8'h10, 1'b1, 1'b0, 1'b0, 15'b111111_000100000);
    dec("dec_10cs", 8'h10, 1'b1, 1'b1, 1'b0, IDLE_V);
    dec("dec_10as", 8'h10, 1'b0, 1'b0, 1'b1, IDLE_V);
    dec("dec_14w",  8'h14, 1'b0, 1'b0, 1'b0, 15'b111110_000000000);
    dec("dec_18r",  8'h18, 1'b1, 1'b0, 1'b0, 15'b111111_000001000);
    dec("dec_1Cr",  8'h1C, 1'b1, 1'b0, 1'b0, 15'b101111_000000000);
    dec("dec_28r",  8'h28, 1'b1, 1'b0, 1'b0, 15'b110111_000000010);
    dec("dec_28w",  8'h28, 1'b0, 1'b0, 1'b0, 15'b111111_000000010);
    dec("dec_3Cw",  8'h3C, 1'b0, 1'b0, 1'b0, 15'b111111_000010000);
    dec("dec_42r",  8'h42, 1'b1, 1'b0, 1'b0, 15'b111111_000000001);
    dec("dec_4Fw",  8'h4F, 1'b0, 1'b0, 1'b0, 15'b111111_000000001);
    dec("dec_58r",  8'h58, 1'b1, 1'b0, 1'b0, 15'b111011_000000000);
    dec("dec_58w",  8'h58, 1'b0, 1'b0, 1'b0, 15'b111111_010000000);
    dec("dec_60r",  8'h60, 1'b1, 1'b0, 1'b0, 15'b111101_000000000);
    dec("dec_60w",  8'h60, 1'b0, 1'b0, 1'b0, IDLE_V);
    dec("dec_20r",  8'h20, 1'b1, 1'b0, 1'b0, IDLE_V);
    push("dmaena_after_dec", 32'h0); chk(32'(dmaena));

`ifdef RESDMAC_FLASH_EN
    @(posedge clk); #1;
    bus(8'h64, 1'b0, 32'h00FFFFFC); tick(); idle();
    push("faddr_load", 32'hFFFFFC); chk(32'(flash_addr));
    fl_wait = 1'b1; fl_rdata = 32'hDEADBEEF;
    bus(8'h68, 1'b1, 32'h0); tick();
    push("rd_flrd", 32'h1); push("rd_fladdr", 32'hFFFFFC); push("rd_term0", 32'h0);
    chk(32'(fl_rd)); chk(32'(fl_addr)); chk(32'(flash_term));
    tick(); tick();
    push("rd_wait_flrd", 32'h1); push("rd_wait_term", 32'h0);
    chk(32'(fl_rd)); chk(32'(flash_term));
    fl_wait = 1'b0; tick();
    push("rd_term", 32'h1); push("rd_flrd_drop", 32'h0); push("rd_data", 32'hDEADBEEF);
    push("rd_wrap", 32'h0);
    chk(32'(flash_term)); chk(32'(fl_rd)); chk(loc_od); chk(32'(flash_addr));
    tick();
    push("rd_term_hold", 32'h1); chk(32'(flash_term));
    idle(); tick();
    push("rd_term_end", 32'h0); chk(32'(flash_term));
    bus(8'h64, 1'b1, 32'h0);
    push("faddr_rd", 32'h0); chk(loc_od);
    idle();

    bus(8'h68, 1'b0, 32'h12345678); tick();
    push("wr_flwr", 32'h1); push("wr_wdata", 32'h12345678); push("wr_fladdr", 32'h0);
    chk(32'(fl_wr)); chk(fl_wdata); chk(32'(fl_addr));
    tick();
    push("wr_term", 32'h1); push("wr_flwr_drop", 32'h0); push("wr_inc", 32'h4);
    chk(32'(flash_term)); chk(32'(fl_wr)); chk(32'(flash_addr));
    idle(); tick();

    fl_wait = 1'b1;
    bus(8'h68, 1'b1, 32'h0); tick();
    push("rq_flrd", 32'h1); chk(32'(fl_rd));
    rst = 1'b1; tick();
    push("rst_req_flrd", 32'h0); push("rst_req_term", 32'h0);
    chk(32'(fl_rd)); chk(32'(flash_term));
    rst = 1'b0; tick();
    push("rst_req_idle", 32'h1); push("rst_req_fladdr", 32'h0);
    chk(32'(fl_rd)); chk(32'(fl_addr));
    idle(); fl_wait = 1'b0; tick(); tick();
`else
    @(posedge clk); #1;
    bus(8'h64, 1'b0, 32'h00123456); tick(); idle();
    push("nf_faddr", 32'h0); chk(32'(flash_addr));
    bus(8'h64, 1'b1, 32'h0);
    push("nf_faddr_rd", 32'h0); chk(loc_od);
    fl_wait = 1'b0; fl_rdata = 32'hDEADBEEF;
    bus(8'h68, 1'b1, 32'h0); tick(); tick();
    push("nf_flrd", 32'h0); push("nf_term", 32'h0); push("nf_fdata_rd", 32'h0);
    chk(32'(fl_rd)); chk(32'(flash_term)); chk(loc_od);
    idle();
    bus(8'h68, 1'b0, 32'hCAFEF00D); tick();
    push("nf_flwr", 32'h0); push("nf_wdata", 32'h0);
    chk(32'(fl_wr)); chk(fl_wdata);
    idle();
`endif

    if (q_exp.size() != 0) begin
      n_total++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", q_exp.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
